// File: rtl/moka_rv32i_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : moka_rv32i_mc_pkg
// Description : Shared types and encodings for the moka RV32I multi-cycle
//               controller. It holds the FSM state encoding, the opcodes,
//               the ALU, immediate and mux select encodings, and the
//               immediate-format decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package moka_rv32i_mc_pkg;

    // FSM states. Encoding 15 is unused and recovers to FETCH.
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        JALR     = 4'd11,
        LUI      = 4'd12,
        AUIPC    = 4'd13,
        TRAP     = 4'd14
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLTU = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001
    } alu_ctrl_t;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_t;

    // Operation class handed to the ALU decoder.
    typedef enum logic [1:0] {
        ALUOP_ADD = 2'b00,  // fixed add (addresses, PC+4, targets)
        ALUOP_SUB = 2'b01,  // branch compare
        ALUOP_R   = 2'b10,  // register-register, funct7 selects SUB/SRA
        ALUOP_I   = 2'b11   // register-immediate, funct7 selects SRA only
    } alu_op_t;

    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_OLDPC  = 2'b01;
    localparam logic [1:0] SRCA_RD1    = 2'b10;
    localparam logic [1:0] SRCA_ZERO   = 2'b11;

    localparam logic [1:0] SRCB_RD2    = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_DATA    = 2'b01;
    localparam logic [1:0] RES_ALURES  = 2'b10;

    // Immediate format for a given opcode; unknown opcodes fall back to I.
    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        logic [2:0] v;
        case (op)
            OP_LOAD, OP_JALR, OP_I: v = IMM_I;
            OP_STORE:               v = IMM_S;
            OP_BRANCH:              v = IMM_B;
            OP_JAL:                 v = IMM_J;
            OP_LUI, OP_AUIPC:       v = IMM_U;
            default:                v = IMM_I;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/moka_rv32i_mc_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : moka_rv32i_mc_alu_decoder
// Description : Combinational ALU control decode from the operation class
//               and the instruction funct fields.
// Ports       : alu_op   in  2  operation class (alu_op_t)
//               funct3   in  3  IR[14:12]
//               funct7   in  1  IR[30]
//               alu_ctrl out 4  ALUControl encoding (alu_ctrl_t)
// Revision    : 1.0 - initial release
// ============================================================================
module moka_rv32i_mc_alu_decoder
    import moka_rv32i_mc_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7,
    output logic [3:0] alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_ctrl = ALU_ADD;
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            default: begin
                case (funct3)
                    // IR[30] is part of the immediate for ADDI, so only the
                    // register form may turn an add into a subtract.
                    3'b000:  alu_ctrl = (alu_op == ALUOP_R && funct7) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctrl = ALU_SLL;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b011:  alu_ctrl = ALU_SLTU;
                    3'b100:  alu_ctrl = ALU_XOR;
                    3'b101:  alu_ctrl = funct7 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_ctrl = ALU_OR;
                    default: alu_ctrl = ALU_AND;
                endcase
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/moka_rv32i_mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : moka_rv32i_mc_controller
// Description : Main control FSM of the multi-cycle moka RV32I core. It
//               sequences each instruction through 3-5 states over a shared
//               memory port and ALU.
// Ports       : clk, rst_n (sync, active-low)
//               op/funct3/funct7  instruction register fields
//               zero              ALU zero flag
//               mem_ready         memory completes the request this cycle
//               mem_req/MemWrite/AdrSrc          memory port control
//               IRWrite/PCWrite/RegWrite         register enables
//               ImmSrc/ALUSrcA/ALUSrcB/ALUControl/ResultSrc  datapath muxes
//               state/illegal_instr/instret      status
// Revision    : 1.0 - initial release
// ============================================================================
module moka_rv32i_mc_controller
    import moka_rv32i_mc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int STATE_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic                  funct7,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  MemWrite,
    output logic                  AdrSrc,
    output logic                  IRWrite,
    output logic                  PCWrite,
    output logic                  RegWrite,
    output logic [2:0]            ImmSrc,
    output logic [1:0]            ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [3:0]            ALUControl,
    output logic [1:0]            ResultSrc,
    output logic [STATE_W-1:0]    state,
    output logic                  illegal_instr,
    output logic [DATA_WIDTH-1:0] instret
);

    state_t                r_state;
    state_t                w_next;
    logic                  r_illegal;
    logic [DATA_WIDTH-1:0] r_instret;
    logic [1:0]            w_alu_op;
    logic [3:0]            w_alu_ctrl;

    // ------------------------------------------------------------------
    // State, retired-instruction counter and sticky trap flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= FETCH;
            r_instret <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            // An instruction retires on its return to FETCH; TRAP never
            // returns, so trapped instructions are not counted.
            if (r_state != FETCH && w_next == FETCH)
                r_instret <= r_instret + DATA_WIDTH'(1);
            if (w_next == TRAP)
                r_illegal <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH:    w_next = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: w_next = MEMADR;
                    OP_R:              w_next = EXECR;
                    OP_I:              w_next = EXECI;
                    OP_BRANCH:         w_next = (funct3[2:1] == 2'b00) ? BRANCH : TRAP;
                    OP_JAL:            w_next = JAL;
                    OP_JALR:           w_next = JALR;
                    OP_LUI:            w_next = LUI;
                    OP_AUIPC:          w_next = AUIPC;
                    default:           w_next = TRAP;
                endcase
            end
            MEMADR:   w_next = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
            MEMREAD:  w_next = mem_ready ? MEMWB : MEMREAD;
            MEMWB:    w_next = FETCH;
            MEMWRITE: w_next = mem_ready ? FETCH : MEMWRITE;
            EXECR:    w_next = ALUWB;
            EXECI:    w_next = ALUWB;
            ALUWB:    w_next = FETCH;
            BRANCH:   w_next = FETCH;
            JALR:     w_next = JAL;
            JAL:      w_next = ALUWB;
            LUI:      w_next = ALUWB;
            AUIPC:    w_next = ALUWB;
            TRAP:     w_next = TRAP;
            default:  w_next = FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // ALU operation class per state
    // ------------------------------------------------------------------
    always_comb begin
        w_alu_op = ALUOP_ADD;
        case (r_state)
            EXECR:   w_alu_op = ALUOP_R;
            EXECI:   w_alu_op = ALUOP_I;
            BRANCH:  w_alu_op = ALUOP_SUB;
            default: w_alu_op = ALUOP_ADD;
        endcase
    end

    moka_rv32i_mc_alu_decoder u_alu_decoder (
        .alu_op   (w_alu_op),
        .funct3   (funct3),
        .funct7   (funct7),
        .alu_ctrl (w_alu_ctrl)
    );

    // ------------------------------------------------------------------
    // Datapath control outputs
    // ------------------------------------------------------------------
    always_comb begin
        mem_req   = 1'b0;
        MemWrite  = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        ImmSrc    = imm_src_of(op);
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RD2;
        ResultSrc = RES_ALUOUT;
        case (r_state)
            FETCH: begin
                // PC+4 goes straight from the ALU into PC while the fetched
                // word lands in IR, both on the completing cycle.
                mem_req   = 1'b1;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
            end
            DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
            end
            MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
            end
            MEMWRITE: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
            end
            EXECR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_RD2;
            end
            EXECI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
            end
            ALUWB: begin
                ResultSrc = RES_ALUOUT;
                RegWrite  = 1'b1;
            end
            BRANCH: begin
                // funct3[0] distinguishes bne from beq.
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_RD2;
                PCWrite = zero ^ funct3[0];
            end
            JALR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
            end
            JAL: begin
                // PC takes the target held in ALUOut while the ALU forms
                // OldPC+4 for the link writeback in ALUWB.
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                PCWrite = 1'b1;
            end
            LUI: begin
                ALUSrcA = SRCA_ZERO;
                ALUSrcB = SRCB_IMM;
            end
            AUIPC: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            default: begin
            end
        endcase

        // Hold every enable and mux at zero while reset is asserted so an
        // abandoned instruction cannot write anything back.
        if (!rst_n) begin
            mem_req   = 1'b0;
            MemWrite  = 1'b0;
            AdrSrc    = 1'b0;
            IRWrite   = 1'b0;
            PCWrite   = 1'b0;
            RegWrite  = 1'b0;
            ImmSrc    = 3'b000;
            ALUSrcA   = 2'b00;
            ALUSrcB   = 2'b00;
            ResultSrc = 2'b00;
        end
    end

    assign ALUControl    = rst_n ? w_alu_ctrl : 4'b0000;
    assign state         = STATE_W'(r_state);
    assign illegal_instr = r_illegal;
    assign instret       = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_moka_rv32i_mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_moka_rv32i_mc_controller
// Description : Scoreboard bench for the multi-cycle controller. The driver
//               applies directed instruction fields and queues the expected
//               per-cycle control word; the monitor pops and compares it on
//               the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_moka_rv32i_mc_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
    logic [2:0]  ImmSrc;
    logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
    logic [3:0]  ALUControl;
    logic [3:0]  state;
    logic        illegal_instr;
    logic [31:0] instret;

    always #5 clk = ~clk;

    moka_rv32i_mc_controller #(
        .DATA_WIDTH (32),
        .STATE_W    (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .op            (op),
        .funct3        (funct3),
        .funct7        (funct7),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .MemWrite      (MemWrite),
        .AdrSrc        (AdrSrc),
        .IRWrite       (IRWrite),
        .PCWrite       (PCWrite),
        .RegWrite      (RegWrite),
        .ImmSrc        (ImmSrc),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .ALUControl    (ALUControl),
        .ResultSrc     (ResultSrc),
        .state         (state),
        .illegal_instr (illegal_instr),
        .instret       (instret)
    );

    // ctrl = {state, mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
    //         ImmSrc, ALUSrcA, ALUSrcB, ALUControl, ResultSrc, illegal}
    typedef struct {
        string       nm;
        logic [23:0] ctrl;
        logic [31:0] ir;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_ir;

    // Queue the expected outputs for the current cycle, then advance.
    task automatic step(input string nm, input logic [3:0] st, input logic [5:0] en,
                        input logic [2:0] imm, input logic [1:0] sa, input logic [1:0] sb,
                        input logic [3:0] alu, input logic [1:0] rs, input logic ill);
        exp_t e;
        e.nm   = nm;
        e.ctrl = {st, en, imm, sa, sb, alu, rs, ill};
        e.ir   = exp_ir;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: one expected entry per cycle, compared mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                exp_t        e;
                logic [23:0] act;
                e   = sb_q.pop_front();
                act = {state, mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                       ImmSrc, ALUSrcA, ALUSrcB, ALUControl, ResultSrc, illegal_instr};
                checks++;
                if (act !== e.ctrl) begin
                    failures++;
                    $display("FAIL %s ctrl: got %h expected %h", e.nm, act, e.ctrl);
                end
                checks++;
                if (instret !== e.ir) begin
                    failures++;
                    $display("FAIL %s instret: got %0d expected %0d", e.nm, instret, e.ir);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        rst_n = 1'b0; op = 7'b0110011; funct3 = 3'b000; funct7 = 1'b0;
        zero = 1'b0; mem_ready = 1'b0; exp_ir = 32'd0;
        @(posedge clk);
        #1;
        step("rst_hold", 4'd0, 6'b000000, 3'b000, 2'b00, 2'b00, 4'h0, 2'b00, 1'b0);
        rst_n = 1'b1;

        // Idle fetch: memory never answers.
        for (int i = 0; i < 10; i++)
            step("idle_fetch", 4'd0, 6'b100000, 3'b000, 2'b00, 2'b10, 4'h0, 2'b10, 1'b0);

        // add
        mem_ready = 1'b1;
        step("add_fetch",  4'd0, 6'b100110, 3'b000, 2'b00, 2'b10, 4'h0, 2'b10, 1'b0);
        mem_ready = 1'b0;
        step("add_decode", 4'd1, 6'b000000, 3'b000, 2'b01, 2'b01, 4'h0, 2'b00, 1'b0);
        step("add_execr",  4'd6, 6'b000000, 3'b000, 2'b10, 2'b00, 4'h0, 2'b00, 1'b0);
        step("add_aluwb",  4'd8, 6'b000001, 3'b000, 2'b00, 2'b00, 4'h0, 2'b00, 1'b0);
        exp_ir = 32'd1;

        // sra (R-type, funct7 set)
        funct3 = 3'b101; funct7 = 1'b1; mem_ready = 1'b1;
        step("sra_fetch",  4'd0, 6'b100110, 3'b000, 2'b00, 2'b10, 4'h0, 2'b10, 1'b0);
        mem_ready = 1'b0;
        step("sra_decode", 4'd1, 6'b000000, 3'b000, 2'b01, 2'b01, 4'h0, 2'b00, 1'b0);
        step("sra_execr",  4'd6, 6'b000000, 3'b000, 2'b10, 2'b00, 4'h9, 2'b00, 1'b0);
        step("sra_aluwb",  4'd8, 6'b000001, 3'b000, 2'b00, 2'b00, 4'h0, 2'b00, 1'b0);
        exp_ir = 32'd2;

        // addi with IR[30] set must still add
        op = 7'b0010011; funct3 = 3'b000; funct7 = 1'b1; mem_ready = 1'b1;
        step("addi_fetch",  4'd0, 6'b100110, 3'b000, 2'b00, 2'b10, 4'h0, 2'b10, 1'b0);
        mem_ready = 1'b0;
        step("addi_decode", 4'd1, 6'b000000, 3'b000, 2'b01, 2'b01, 4'h0, 2'b00, 1'b0);
        step("addi_execi",  4'd7, 6'b000000, 3'b000, 2'b10, 2'b01, 4'h0, 2'b00, 1'b0);
        step("addi_aluwb",  4'd8, 6'b000001, 3'b000, 2'b00, 2'b00, 4'h0, 2'b00, 1'b0);
        exp_ir = 32'd3;

        // lw with two wait cycles in MEMREAD
        op = 7'b0000011; funct3 = 3'b010; funct7 = 1'b0; mem_ready = 1'b1;
        step("lw_fetch",  4'd0, 6'b100110, 3'b000, 2'b00, 2'b10, 4'h0, 2'b10, 1'b0);
        mem_ready = 1'b0;
        step("lw_decode", 4'd1, 6'b000000, 3'b000, 2'b01, 2'b01, 4'h0, 2'b00, 1'b0);
        step("lw_memadr", 4'd2, 6'b000000, 3'b000, 2'b10, 2'b01, 4'h0, 2'b00, 1'b0);
        step("lw_wait1",  4'd3, 6'b101000, 3'b000, 2'b00, 2'b00, 4'h0, 2'b00, 1'b0);
        step("lw_wait2",  4'd3, 6'b101000, 3'b000, 2'b00, 2'b00, 4'h0, 2'b00, 1'b0);
        mem_ready = 1'b1;
        step("lw_read",   4'd3, 6'b101000, 3'b000, 2'b00, 2'b00, 4'h0, 2'b00, 1'b0);
        mem_ready = 1'b0;
        step("lw_memwb",  4'd4, 6'b000001, 3'b000, 2'b00, 2'b00, 4'h0, 2'b01, 1'b0);
        exp_ir = 32'd4;

        // beq taken on zero
        op = 7'b1100011; funct3 = 3'b000; zero = 1'b1; mem_ready = 1'b1;
        step("beq_fetch",  4'd0, 6'b100110, 3'b010, 2'b00, 2'b10, 4'h0, 2'b10, 1'b0);
        mem_ready = 1'b0;
        step("beq_decode", 4'd1, 6'b000000, 3'b010, 2'b01, 2'b01, 4'h0, 2'b00, 1'b0);
        step("beq_branch", 4'd9, 6'b000010, 3'b010, 2'b10, 2'b00, 4'h1, 2'b00, 1'b0);
        exp_ir = 32'd5;

        // bne not taken on zero
        funct3 = 3'b001; mem_ready = 1'b1;
        step("bne_fetch",  4'd0, 6'b100110, 3'b010, 2'b00, 2'b10, 4'h0, 2'b10, 1'b0);
        mem_ready = 1'b0;
        step("bne_decode", 4'd1, 6'b000000, 3'b010, 2'b01, 2'b01, 4'h0, 2'b00, 1'b0);
        step("bne_branch", 4'd9, 6'b000000, 3'b010, 2'b10, 2'b00, 4'h1, 2'b00, 1'b0);
        exp_ir = 32'd6;

        // jal
        op = 7'b1101111; funct3 = 3'b000; zero = 1'b0; mem_ready = 1'b1;
        step("jal_fetch",  4'd0, 6'b100110, 3'b011, 2'b00, 2'b10, 4'h0, 2'b10, 1'b0);
        mem_ready = 1'b0;
        step("jal_decode", 4'd1, 6'b000000, 3'b011, 2'b01, 2'b01, 4'h0, 2'b00, 1'b0);
        step("jal_jal",    4'd10, 6'b000010, 3'b011, 2'b01, 2'b10, 4'h0, 2'b00, 1'b0);
        step("jal_aluwb",  4'd8, 6'b000001, 3'b011, 2'b00, 2'b00, 4'h0, 2'b00, 1'b0);
        exp_ir = 32'd7;

        // sw abandoned by reset while waiting in MEMWRITE
        op = 7'b0100011; funct3 = 3'b010; mem_ready = 1'b1;
        step("sw_fetch",  4'd0, 6'b100110, 3'b001, 2'b00, 2'b10, 4'h0, 2'b10, 1'b0);
        mem_ready = 1'b0;
        step("sw_decode", 4'd1, 6'b000000, 3'b001, 2'b01, 2'b01, 4'h0, 2'b00, 1'b0);
        step("sw_memadr", 4'd2, 6'b000000, 3'b001, 2'b10, 2'b01, 4'h0, 2'b00, 1'b0);
        step("sw_wait1",  4'd5, 6'b111000, 3'b001, 2'b00, 2'b00, 4'h0, 2'b00, 1'b0);
        step("sw_wait2",  4'd5, 6'b111000, 3'b001, 2'b00, 2'b00, 4'h0, 2'b00, 1'b0);
        rst_n = 1'b0;
        step("sw_reset",  4'd5, 6'b000000, 3'b000, 2'b00, 2'b00, 4'h0, 2'b00, 1'b0);
        rst_n = 1'b1;
        exp_ir = 32'd0;
        step("sw_after_reset", 4'd0, 6'b100000, 3'b001, 2'b00, 2'b10, 4'h0, 2'b10, 1'b0);

        // Illegal opcode traps and stays trapped
        op = 7'b1111111; funct3 = 3'b000; mem_ready = 1'b1;
        step("ill_fetch",  4'd0, 6'b100110, 3'b000, 2'b00, 2'b10, 4'h0, 2'b10, 1'b0);
        step("ill_decode", 4'd1, 6'b000000, 3'b000, 2'b01, 2'b01, 4'h0, 2'b00, 1'b0);
        for (int i = 0; i < 20; i++)
            step("ill_trap", 4'd14, 6'b000000, 3'b000, 2'b00, 2'b00, 4'h0, 2'b00, 1'b1);
        rst_n = 1'b0;
        step("trap_reset", 4'd14, 6'b000000, 3'b000, 2'b00, 2'b00, 4'h0, 2'b00, 1'b1);
        rst_n = 1'b1;

        // Unsupported branch funct3 traps
        op = 7'b1100011; funct3 = 3'b010;
        step("bx_fetch",  4'd0, 6'b100110, 3'b010, 2'b00, 2'b10, 4'h0, 2'b10, 1'b0);
        step("bx_decode", 4'd1, 6'b000000, 3'b010, 2'b01, 2'b01, 4'h0, 2'b00, 1'b0);
        for (int i = 0; i < 5; i++)
            step("bx_trap", 4'd14, 6'b000000, 3'b010, 2'b00, 2'b00, 4'h0, 2'b00, 1'b1);

        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/moka_rv32i_mc_controller.md
Name: moka_rv32i_mc_controller

Overview:
Main control FSM for the multi-cycle variant of the moka RV32I core. It shares one unified memory port and one ALU across fetch, address generation, execute and writeback. Each instruction is sequenced through 3-5 states, and the block drives the same control-signal set as the single-cycle core plus the multi-cycle register enables. It sits between the instruction register fields and the datapath muxes/enables, and handshakes with the memory on mem_req/mem_ready.

Parameters:
DATA_WIDTH, 32, width of the retired-instruction counter
STATE_W, 4, width of the exported state encoding

Ports:
clk  in  1  core clock, all state changes on rising edge
rst_n  in  1  synchronous, active-low reset
op  in  7  instruction opcode (IR[6:0])
funct3  in  3  IR[14:12]
funct7  in  1  IR[30]
zero  in  1  ALU zero flag, combinational from current ALU operation
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request, held with stable address until mem_ready
MemWrite  out  1  request is a store (valid only with mem_req)
AdrSrc  out  1  0=PC, 1=ALUOut as memory address
IRWrite  out  1  load IR and OldPC
PCWrite  out  1  load PC from Result
RegWrite  out  1  register file write
ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
ALUSrcA  out  2  00 PC, 01 OldPC, 10 RD1 reg, 11 zero
ALUSrcB  out  2  00 RD2 reg, 01 ImmExt, 10 constant 4
ALUControl  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA
ResultSrc  out  2  00 ALUOut, 01 Data reg, 10 ALUResult
state  out  STATE_W  current state, debug/bench visibility
illegal_instr  out  1  sticky trap flag
instret  out  DATA_WIDTH  retired instruction count

Behaviour:
- Reset (rst_n=0 at edge): state=FETCH, instret=0, illegal_instr=0.
- While rst_n is low, all enables (mem_req, MemWrite, IRWrite, PCWrite, RegWrite) are 0 and muxes are 0. A reset mid-instruction abandons it without writeback.
- Outputs are combinational from state, op, funct3, funct7, zero and mem_ready (Mealy only for IRWrite, PCWrite and branch PCWrite). Unlisted outputs are 0.
- ImmSrc is decoded from op in every state: load/jalr/OP-IMM→I, store→S, branch→B, jal→J, lui/auipc→U, else 000.
- FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ADD, ResultSrc=10. IRWrite=PCWrite=mem_ready. Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ADD (branch/jal target into ALUOut). Next state by op:
  - 0000011/0100011→MEMADR
  - 0110011→EXECR
  - 0010011→EXECI
  - 1100011→BRANCH when funct3 is 000 or 001, else TRAP
  - 1101111→JAL
  - 1100111→JALR
  - 0110111→LUI
  - 0010111→AUIPC
  - anything else→TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, ADD. Goes to MEMREAD if op is a load, else MEMWRITE.
- MEMREAD: mem_req=1, AdrSrc=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: mem_req=1, MemWrite=1, AdrSrc=1. Waits for mem_ready, then goes to FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, then ALUWB.
  - ALU op decode by funct3: 000 ADD, or SUB if funct7=1; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA if funct7=1; 110 OR; 111 AND.
- EXECI: ALUSrcA=10, ALUSrcB=01, then ALUWB. Same decode, except funct7 is ignored for 000 (ADDI is never SUB). funct7 is honoured for 101 (SRAI).
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, SUB, ResultSrc=00. PCWrite = zero XOR funct3[0] (beq taken on zero, bne on !zero). Then FETCH.
- JALR: ALUSrcA=10, ALUSrcB=01, ADD (target into ALUOut; LSB not cleared), then JAL.
- JAL: ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=00, PCWrite=1. Then ALUWB, which writes OldPC+4.
- LUI: ALUSrcA=11, ALUSrcB=01, ADD, then ALUWB. AUIPC: ALUSrcA=01, ALUSrcB=01, ADD, then ALUWB.
- TRAP: illegal_instr=1, all enables 0. Absorbing until reset. instret is not incremented.
- instret increments by 1 (wrapping modulo 2^DATA_WIDTH) on every transition into FETCH from a non-FETCH state.
- Unused state encodings go to FETCH on the next edge.
- mem_ready is ignored outside FETCH/MEMREAD/MEMWRITE.

Decomposition:
- Package moka_rv32i_mc_pkg holds:
  - state_t enum (FETCH=0 … TRAP)
  - opcode localparams (OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC)
  - alu_ctrl_t and imm_src_t encodings
  - ALUSrcA/ALUSrcB/ResultSrc constants
- One sub-module, moka_rv32i_mc_alu_decoder: purely combinational (funct3, funct7, alu_op class) → ALUControl, shared by EXECR/EXECI/MEMADR/BRANCH.

Test Plan:
- Reset, then idle with mem_ready=0 → state=FETCH, mem_req=1, IRWrite=0, instret=0 for 10 cycles.
- add (op=0110011, funct3=000, funct7=0), mem_ready=1 in fetch → states FETCH, DECODE, EXECR, ALUWB, FETCH. ALUControl=0000 in EXECR, RegWrite=1 only in ALUWB, instret=1.
- lw with mem_ready delayed 2 cycles in MEMREAD → MEMREAD held 3 cycles with AdrSrc=1 stable, then MEMWB with ResultSrc=01 and RegWrite=1. Total 7 cycles with a 1-cycle fetch.
- beq with zero=1, then bne with zero=1 → PCWrite=1 in BRANCH for beq, 0 for bne. ALUControl=0001 both times.
- op=1111111, then funct3=010 on a branch (after reset) → TRAP, illegal_instr=1 persists for 20 cycles, no enables asserted, instret frozen.
- rst_n=0 during MEMWRITE while waiting on mem_ready → next cycle state=FETCH, MemWrite=0, instret=0.
